// File: rtl/scale_tile_pack_pkg.sv
// scale_tile_pack_pkg
//   Constants and types shared by the scale tile packer and the dequant
//   controller that pops the packed tiles.
//   Contents: default geometry (lanes, field widths, tile size), derived
//   beat count and per-beat field widths, FSM state enum, beat-count helper.
package scale_tile_pack_pkg;

    localparam int unsigned LANES_NUM_DEF = 16;
    localparam int unsigned FP_MANT_W_DEF = 23;
    localparam int unsigned FP_EXP_W_DEF  = 8;
    localparam int unsigned ELEMS_DEF     = 256;

    localparam int unsigned BEATS       = ELEMS_DEF / LANES_NUM_DEF;
    localparam int unsigned LANE_MANT_W = LANES_NUM_DEF * FP_MANT_W_DEF;
    localparam int unsigned LANE_EXP_W  = LANES_NUM_DEF * FP_EXP_W_DEF;

    typedef enum logic {
        FILL = 1'b0,
        PUSH = 1'b1
    } state_e;

    function automatic int unsigned beats_of(input int unsigned elems,
                                             input int unsigned lanes);
        return elems / lanes;
    endfunction

endpackage

// File: rtl/scale_tile_pack_shift.sv
// lane_shift_pack
//   Tile-wide shift-in register. Each insert shifts the contents right by
//   one lane group and places the new beat in the top group, so the first
//   beat of a tile ends up in the lowest group.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset (clears contents)
//     clr_i     : clear to zero (takes priority over shift_i)
//     shift_i   : insert beat_i into the top group
//     empty_i   : insert into an empty register (all other groups zero)
//     beat_i    : one lane group
//     buf_o     : register contents
module lane_shift_pack #(
    parameter int unsigned W  = 256,
    parameter int unsigned LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          shift_i,
    input  logic          empty_i,
    input  logic [LW-1:0] beat_i,
    output logic [W-1:0]  buf_o
);

    logic [W-1:0] buf_q;
    logic [W-1:0] buf_d;
    logic [W-1:0] ins_empty;
    logic [W-1:0] ins_shift;

    // A single-group register has nothing to shift down.
    generate
        if (W == LW) begin : g_single
            assign ins_empty = beat_i;
            assign ins_shift = beat_i;
        end else begin : g_multi
            assign ins_empty = {beat_i, {(W-LW){1'b0}}};
            assign ins_shift = {beat_i, buf_q[W-1:LW]};
        end
    endgenerate

    always_comb begin
        buf_d = buf_q;
        if (clr_i) begin
            buf_d = '0;
        end else if (shift_i) begin
            buf_d = empty_i ? ins_empty : ins_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign buf_o = buf_q;

endmodule

// File: rtl/scale_tile_pack.sv
// scale_tile_pack
//   Collects LANES_NUM-wide beats of FP scales (mantissa + exponent) into a
//   full tile of ELEMS elements and pushes the tile as one wide word into
//   the scale FIFO. Beat k of a tile lands in group k (first beat lowest).
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     in_valid_i/ready_o: beat handshake
//     in_mant_lanes_i   : beat mantissas, lane 0 in the LSBs
//     in_exp_lanes_i    : beat exponents, lane 0 in the LSBs
//     abort_i           : discard the partial tile (ignored while pushing)
//     fifo_full_i       : scale FIFO full
//     fifo_push_o       : push strobe
//     fifo_mant_full_o  : packed tile mantissas
//     fifo_exp_full_o   : packed tile exponents
//     tiles_pushed_o    : wrapping count of tiles pushed
module scale_tile_pack
    import scale_tile_pack_pkg::*;
#(
    parameter int unsigned LANES_NUM = LANES_NUM_DEF,
    parameter int unsigned FP_MANT_W = FP_MANT_W_DEF,
    parameter int unsigned FP_EXP_W  = FP_EXP_W_DEF,
    parameter int unsigned ELEMS     = ELEMS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [LANES_NUM*FP_MANT_W-1:0] in_mant_lanes_i,
    input  logic [LANES_NUM*FP_EXP_W-1:0]  in_exp_lanes_i,
    input  logic                          abort_i,
    input  logic                          fifo_full_i,
    output logic                          fifo_push_o,
    output logic [FP_MANT_W*ELEMS-1:0]    fifo_mant_full_o,
    output logic [FP_EXP_W*ELEMS-1:0]     fifo_exp_full_o,
    output logic [15:0]                   tiles_pushed_o
);

    localparam int unsigned TILE_BEATS = beats_of(ELEMS, LANES_NUM);
    localparam int unsigned LANE_MW    = LANES_NUM * FP_MANT_W;
    localparam int unsigned LANE_EW    = LANES_NUM * FP_EXP_W;
    localparam int unsigned CNT_W      = $clog2(TILE_BEATS) + 1;

    generate
        if ((ELEMS % LANES_NUM) != 0) begin : g_bad_geometry
            $error("scale_tile_pack: ELEMS must be a multiple of LANES_NUM");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        tiles_q, tiles_d;

    logic in_ready;
    logic push;
    logic hs;
    logic clr;
    logic in_push;

    always_comb begin
        in_push  = (state_q == PUSH);
        push     = in_push && !fifo_full_i;
        in_ready = !in_push || !fifo_full_i;
        // An abort in FILL still shows ready but swallows the beat.
        clr      = !in_push && abort_i;
        hs       = in_valid_i && in_ready && !clr;

        state_d = state_q;
        cnt_d   = cnt_q;
        tiles_d = tiles_q;

        if (!in_push) begin
            if (clr) begin
                cnt_d = '0;
            end else if (hs) begin
                if (cnt_q == CNT_W'(TILE_BEATS - 1)) begin
                    state_d = PUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (push) begin
            tiles_d = tiles_q + 16'd1;
            state_d = FILL;
            // A beat taken in the push cycle starts the next tile; with a
            // single-beat tile it completes that tile immediately.
            if (hs) begin
                if (TILE_BEATS == 1) begin
                    state_d = PUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            tiles_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tiles_q <= tiles_d;
        end
    end

    lane_shift_pack #(
        .W  (FP_MANT_W * ELEMS),
        .LW (LANE_MW)
    ) u_mant_buf (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .shift_i (hs),
        .empty_i (in_push),
        .beat_i  (in_mant_lanes_i),
        .buf_o   (fifo_mant_full_o)
    );

    lane_shift_pack #(
        .W  (FP_EXP_W * ELEMS),
        .LW (LANE_EW)
    ) u_exp_buf (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .shift_i (hs),
        .empty_i (in_push),
        .beat_i  (in_exp_lanes_i),
        .buf_o   (fifo_exp_full_o)
    );

    assign in_ready_o     = in_ready;
    assign fifo_push_o    = push;
    assign tiles_pushed_o = tiles_q;

endmodule
